// File: rtl/div_pkg.sv
// Shared types and constants for the 19-by-8 signed sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  localparam int DEF_DVD_W = 19;
  localparam int DEF_DVS_W = 8;
  localparam int DEF_Q_W   = 11;

  localparam logic [DEF_Q_W-1:0] Q_MAX = 11'h3FF;
  localparam logic [DEF_Q_W-1:0] Q_MIN = 11'h400;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] prem,
  input  logic         bit_in,
  input  logic [W:0]   dvs_mag,
  output logic [W-1:0] prem_next,
  output logic         q_bit
);

  logic [W:0]   shifted_s;
  logic [W-1:0] diff_s;

  // Remainder stays below the divisor magnitude, so W bits always hold the kept value.
  always_comb begin
    shifted_s = {prem, bit_in};
    q_bit     = (shifted_s >= dvs_mag);
    diff_s    = shifted_s[W-1:0] - dvs_mag[W-1:0];
    if (q_bit) begin
      prem_next = diff_s;
    end else begin
      prem_next = shifted_s[W-1:0];
    end
  end

endmodule

// File: rtl/div19sx8s.sv
// Sequential signed divider, 19-bit dividend by 8-bit divisor, fixed 21-cycle latency.
module div19sx8s
  import div_pkg::*;
#(
  parameter int DVD_W = DEF_DVD_W,
  parameter int DVS_W = DEF_DVS_W,
  parameter int Q_W   = DEF_Q_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(DVD_W);
  localparam logic [DVD_W-1:0] Q_MAX_EXT = {{(DVD_W-Q_W){1'b0}}, Q_MAX};
  localparam logic [DVD_W-1:0] Q_MIN_EXT = {{(DVD_W-Q_W){1'b0}}, Q_MIN};

  div_state_e state_r, state_s;

  logic [DVD_W-1:0] dvd_raw_r;
  logic [DVS_W-1:0] dvs_raw_r;
  logic             dvd_neg_r;
  logic             q_neg_r;
  logic [DVD_W-1:0] dvd_mag_r;
  logic [DVS_W:0]   dvs_mag_r;
  logic [DVS_W-1:0] prem_r;
  logic [DVD_W-1:0] qmag_r;
  logic [CNT_W-1:0] cnt_r;

  logic             busy_r, done_r, dbz_r, ovf_r;
  logic [Q_W-1:0]   quotient_r;
  logic [DVS_W-1:0] remainder_r;

  logic [DVS_W-1:0] prem_next_s;
  logic             q_bit_s;
  logic [Q_W-1:0]   fix_q_s;
  logic [DVS_W-1:0] fix_r_s;
  logic             fix_ovf_s, fix_dbz_s;

  div_step #(.W(DVS_W)) u_step (
    .prem      (prem_r),
    .bit_in    (dvd_mag_r[DVD_W-1]),
    .dvs_mag   (dvs_mag_r),
    .prem_next (prem_next_s),
    .q_bit     (q_bit_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? LOAD : IDLE;
      LOAD:    state_s = DIV;
      DIV:     state_s = (cnt_r == {CNT_W{1'b0}}) ? FIX : DIV;
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sign and saturation fix-up of the finished magnitudes.
  always_comb begin
    fix_q_s   = {Q_W{1'b0}};
    fix_r_s   = {DVS_W{1'b0}};
    fix_ovf_s = 1'b0;
    fix_dbz_s = 1'b0;
    if (dvs_mag_r == {(DVS_W+1){1'b0}}) begin
      fix_dbz_s = 1'b1;
      fix_q_s   = dvd_neg_r ? Q_MIN : Q_MAX;
    end else begin
      fix_r_s = dvd_neg_r ? ({DVS_W{1'b0}} - prem_r) : prem_r;
      if (q_neg_r) begin
        if (qmag_r > Q_MIN_EXT) begin
          fix_q_s   = Q_MIN;
          fix_ovf_s = 1'b1;
        end else begin
          fix_q_s = {Q_W{1'b0}} - qmag_r[Q_W-1:0];
        end
      end else begin
        if (qmag_r > Q_MAX_EXT) begin
          fix_q_s   = Q_MAX;
          fix_ovf_s = 1'b1;
        end else begin
          fix_q_s = qmag_r[Q_W-1:0];
        end
      end
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_raw_r   <= {DVD_W{1'b0}};
      dvs_raw_r   <= {DVS_W{1'b0}};
      dvd_neg_r   <= 1'b0;
      q_neg_r     <= 1'b0;
      dvd_mag_r   <= {DVD_W{1'b0}};
      dvs_mag_r   <= {(DVS_W+1){1'b0}};
      prem_r      <= {DVS_W{1'b0}};
      qmag_r      <= {DVD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
      quotient_r  <= {Q_W{1'b0}};
      remainder_r <= {DVS_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            dvd_raw_r <= dividend;
            dvs_raw_r <= divisor;
            dvd_neg_r <= dividend[DVD_W-1];
            q_neg_r   <= dividend[DVD_W-1] ^ divisor[DVS_W-1];
            busy_r    <= 1'b1;
          end
        end
        LOAD: begin
          // Magnitudes are unsigned, so the most negative operands convert exactly.
          dvd_mag_r <= dvd_neg_r ? ({DVD_W{1'b0}} - dvd_raw_r) : dvd_raw_r;
          dvs_mag_r <= dvs_raw_r[DVS_W-1] ?
                       ({(DVS_W+1){1'b0}} - {dvs_raw_r[DVS_W-1], dvs_raw_r}) :
                       {1'b0, dvs_raw_r};
          prem_r    <= {DVS_W{1'b0}};
          qmag_r    <= {DVD_W{1'b0}};
          cnt_r     <= CNT_W'(DVD_W-1);
        end
        DIV: begin
          prem_r    <= prem_next_s;
          qmag_r    <= {qmag_r[DVD_W-2:0], q_bit_s};
          dvd_mag_r <= {dvd_mag_r[DVD_W-2:0], 1'b0};
          cnt_r     <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
        FIX: begin
          quotient_r  <= fix_q_s;
          remainder_r <= fix_r_s;
          ovf_r       <= fix_ovf_s;
          dbz_r       <= fix_dbz_s;
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_div19sx8s.sv
// Self-checking bench for div19sx8s: directed corner cases, control behaviour, random regression.
module tb_div19sx8s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [18:0] dividend = 19'd0;
  logic [7:0]  divisor = 8'd0;
  logic        busy, done, div_by_zero, overflow;
  logic [10:0] quotient;
  logic [7:0]  remainder;

  int checks = 0;
  int errors = 0;

  div19sx8s dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference: integer division truncates toward zero, % takes the dividend's sign.
  function automatic void model(input int a, input int b, output logic [10:0] q,
                                output logic [7:0] r, output logic ovf, output logic dbz);
    int qi, ri;
    ovf = 1'b0;
    dbz = 1'b0;
    if (b == 0) begin
      dbz = 1'b1;
      q   = (a >= 0) ? 11'h3FF : 11'h400;
      r   = 8'h00;
    end else begin
      qi = a / b;
      ri = a % b;
      r  = ri[7:0];
      if (qi > 1023) begin
        q = 11'h3FF; ovf = 1'b1;
      end else if (qi < -1024) begin
        q = 11'h400; ovf = 1'b1;
      end else begin
        q = qi[10:0];
      end
    end
  endfunction

  // Start an operation at a negedge and count edges from acceptance until done is seen.
  task automatic run_op(input int a, input int b, output int lat);
    @(negedge clk);
    start    = 1'b1;
    dividend = a[18:0];
    divisor  = b[7:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk);
    start = 1'b1;
    dividend = 19'd1000;
    divisor = 8'd10;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: got busy=%b, want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    int          a_t [15] = '{1000, -1000, 127, -12800, 262143, -262144, -1024, 500, -500,
                              0, 1023, -1025, 1024, -262144, -7};
    int          b_t [15] = '{10, 7, -128, -128, 1, 1, 1, 0, 0, -5, 1, 1, 1, -128, 2};
    logic [10:0] q_t [15] = '{11'h064, 11'h772, 11'h000, 11'h064, 11'h3FF, 11'h400, 11'h400,
                              11'h3FF, 11'h400, 11'h000, 11'h3FF, 11'h400, 11'h3FF, 11'h3FF,
                              11'h7FD};
    logic [7:0]  r_t [15] = '{8'h00, 8'hFA, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    logic        o_t [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        z_t [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 15; i++) begin
      run_op(a_t[i], b_t[i], lat);
      checks++;
      if (lat != 21) begin
        errors++;
        $display("FAIL dir_latency %0d/%0d: got %0d edges, want 21", a_t[i], b_t[i], lat);
      end
      checks++;
      if ({quotient, remainder, overflow, div_by_zero, busy} !== {q_t[i], r_t[i], o_t[i], z_t[i], 1'b0}) begin
        errors++;
        $display("FAIL dir_result %0d/%0d: got q=%h r=%h ovf=%b dbz=%b busy=%b, want q=%h r=%h ovf=%b dbz=%b busy=0",
                 a_t[i], b_t[i], quotient, remainder, overflow, div_by_zero, busy,
                 q_t[i], r_t[i], o_t[i], z_t[i]);
      end
    end
    // Outputs hold after the done pulse.
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done, quotient, remainder} !== {1'b0, 11'h7FD, 8'hFF}) begin
      errors++;
      $display("FAIL hold: got done=%b q=%h r=%h, want done=0 q=7fd r=ff", done, quotient, remainder);
    end
  endtask

  task automatic test_busy_ignore;
    int lat;
    @(negedge clk);
    start = 1'b1;
    dividend = 19'd1000;
    divisor = 8'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b, want 1", busy);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = -19'sd5000;
    divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 7; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 21 || quotient !== 11'h064 || remainder !== 8'h00) begin
      errors++;
      $display("FAIL busy_ignore: got lat=%0d q=%h r=%h, want lat=21 q=064 r=00", lat, quotient, remainder);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(-1000, 7, lat);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 11'h772) begin
      errors++;
      $display("FAIL b2b_first: got done=%b busy=%b q=%h, want done=1 busy=0 q=772", done, busy, quotient);
    end
    start = 1'b1;
    dividend = 19'd2000;
    divisor = -8'sd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 21 || quotient !== 11'h79C || remainder !== 8'h00) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h, want lat=21 q=79c r=00", lat, quotient, remainder);
    end
  endtask

  task automatic test_rst_mid;
    int seen = 0;
    @(negedge clk);
    start = 1'b1;
    dividend = 19'd1000;
    divisor = 8'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen != 0 || {busy, quotient, remainder, div_by_zero, overflow} !== 29'd0) begin
      errors++;
      $display("FAIL rst_mid: got done_count=%0d busy=%b q=%h r=%h dbz=%b ovf=%b, want all zero",
               seen, busy, quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_random;
    int a, b, lat;
    logic [10:0] eq;
    logic [7:0] er;
    logic eo, ez;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 2047)) - 1024;
      b = 0;
      while (b == 0) b = int'($urandom_range(0, 255)) - 128;
      run_op(a * b, b, lat);
      eq = a[10:0];
      checks++;
      if (lat != 21 || quotient !== eq || remainder !== 8'h00 || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL rand_product %0d*%0d: got lat=%0d q=%h r=%h ovf=%b dbz=%b, want lat=21 q=%h r=00 flags 0",
                 a, b, lat, quotient, remainder, overflow, div_by_zero, eq);
      end
    end
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 524287)) - 262144;
      b = int'($urandom_range(0, 255)) - 128;
      if (i % 4 == 0) a = a / 200;
      model(a, b, eq, er, eo, ez);
      run_op(a, b, lat);
      checks++;
      if (lat != 21 || quotient !== eq || remainder !== er || overflow !== eo || div_by_zero !== ez) begin
        errors++;
        $display("FAIL rand_model %0d/%0d: got lat=%0d q=%h r=%h ovf=%b dbz=%b, want lat=21 q=%h r=%h ovf=%b dbz=%b",
                 a, b, lat, quotient, remainder, overflow, div_by_zero, eq, er, eo, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
